// File: rtl/dtree_class_voter.sv
// dtree_class_voter
//   Majority voter behind the decision-tree classifier. Builds a per-class
//   histogram over WINDOW accepted labels. It then scans the bins, lowest
//   index first, to pick the class with the most votes, and presents that
//   class on a valid/ready output.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      discard the partial window (ACCUM only)
//   in_valid   in_class carries a label
//   in_ready   a sample is accepted this cycle
//   in_class   class label from the tree
//   out_valid  vote result is valid
//   out_ready  consumer takes the result
//   out_class  majority class (lowest index on ties)
//   out_count  number of votes for out_class
//   out_tie    another bin reached the same count
//   err_range  sticky: a label >= N_CLASSES was seen
module dtree_class_voter #(
    parameter int unsigned CLASS_W   = 5,
    parameter int unsigned N_CLASSES = 32,
    parameter int unsigned WINDOW    = 8,
    parameter int unsigned CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CLASS_W-1:0] in_class,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_tie,
    output logic               err_range
);

    localparam int unsigned IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    typedef enum logic [1:0] {
        ACCUM,
        SCAN,
        HOLD
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   bins_q [N_CLASSES];
    logic [CNT_W-1:0]   sample_cnt_q;
    logic [IDX_W-1:0]   scan_idx_q;
    logic [CNT_W-1:0]   best_cnt_q;
    logic [CLASS_W-1:0] best_idx_q;
    logic               tie_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               err_q;

    logic               in_range;
    logic [IDX_W-1:0]   wr_idx;
    logic [CNT_W-1:0]   scan_bin;

    // When every encodable label is a legal class the range check is constant.
    if (N_CLASSES >= (1 << CLASS_W)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (in_class < CLASS_W'(N_CLASSES));
    end

    always_comb begin
        wr_idx   = in_class[IDX_W-1:0];
        scan_bin = bins_q[scan_idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            for (int unsigned i = 0; i < N_CLASSES; i++) bins_q[i] <= '0;
            sample_cnt_q <= '0;
            scan_idx_q   <= '0;
            best_cnt_q   <= '0;
            best_idx_q   <= '0;
            tie_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (flush) begin
                        // flush wins over a same-cycle sample
                        for (int unsigned i = 0; i < N_CLASSES; i++) bins_q[i] <= '0;
                        sample_cnt_q <= '0;
                    end else if (in_valid) begin
                        // out-of-range labels still consume a window slot
                        if (in_range) bins_q[wr_idx] <= bins_q[wr_idx] + CNT_W'(1);
                        else          err_q          <= 1'b1;
                        if (sample_cnt_q == CNT_W'(WINDOW - 1)) begin
                            sample_cnt_q <= '0;
                            state_q      <= SCAN;
                            in_ready_q   <= 1'b0;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    // strict '>' keeps the lowest index on equal counts
                    if (scan_bin > best_cnt_q) begin
                        best_cnt_q <= scan_bin;
                        best_idx_q <= CLASS_W'(scan_idx_q);
                        tie_q      <= 1'b0;
                    end else if (scan_bin == best_cnt_q && scan_bin != '0) begin
                        tie_q      <= 1'b1;
                    end
                    if (scan_idx_q == IDX_W'(N_CLASSES - 1)) begin
                        scan_idx_q  <= '0;
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        scan_idx_q  <= scan_idx_q + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        for (int unsigned i = 0; i < N_CLASSES; i++) bins_q[i] <= '0;
                        best_cnt_q  <= '0;
                        best_idx_q  <= '0;
                        tie_q       <= 1'b0;
                        state_q     <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    // best/tie registers stay zero outside SCAN/HOLD, so they drive the outputs directly
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        out_class = best_idx_q;
        out_count = best_cnt_q;
        out_tie   = tie_q;
        err_range = err_q;
    end

endmodule

// File: tb/tb_dtree_class_voter.sv
module tb_dtree_class_voter;

    localparam int unsigned CLASS_W = 5;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic [7:0][CLASS_W-1:0] labs;
        logic [CLASS_W-1:0]      cls;
        logic [CNT_W-1:0]        cnt;
        logic                    tie;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [CLASS_W-1:0] in_class;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic [CNT_W-1:0]   out_count;
    logic               out_tie;
    logic               err_range;

    logic               b_flush;
    logic               b_in_valid;
    logic               b_in_ready;
    logic [CLASS_W-1:0] b_in_class;
    logic               b_out_valid;
    logic               b_out_ready;
    logic [CLASS_W-1:0] b_out_class;
    logic [CNT_W-1:0]   b_out_count;
    logic               b_out_tie;
    logic               b_err_range;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    dtree_class_voter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_count(out_count), .out_tie(out_tie), .err_range(err_range)
    );

    dtree_class_voter #(.N_CLASSES(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_class(b_in_class),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class),
        .out_count(b_out_count), .out_tie(b_out_tie), .err_range(b_err_range)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int l0, l1, l2, l3, l4, l5, l6, l7,
                                input int c, input int n, input int t);
        vec_t v;
        v.labs[0] = CLASS_W'(l0); v.labs[1] = CLASS_W'(l1);
        v.labs[2] = CLASS_W'(l2); v.labs[3] = CLASS_W'(l3);
        v.labs[4] = CLASS_W'(l4); v.labs[5] = CLASS_W'(l5);
        v.labs[6] = CLASS_W'(l6); v.labs[7] = CLASS_W'(l7);
        v.cls = CLASS_W'(c);
        v.cnt = CNT_W'(n);
        v.tie = t[0];
        return v;
    endfunction

    task automatic send_window(input vec_t v, input bit push);
        if (push) sb.push_back(v);
        chk("in_ready_at_window_start", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_class = v.labs[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and the scoreboard head; completes the handshake if out_ready=1.
    task automatic wait_result(input string name);
        int   n;
        vec_t e;
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk({name, "_latency"}, n, 32);
        if (sb.size() == 0) begin
            chk({name, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_out_valid"}, int'(out_valid), 1);
            chk({name, "_out_class"}, int'(out_class), int'(e.cls));
            chk({name, "_out_count"}, int'(out_count), int'(e.cnt));
            chk({name, "_out_tie"},   int'(out_tie),   int'(e.tie));
            chk({name, "_in_ready_hold"}, int'(in_ready), 0);
        end
        if (out_ready) begin
            step();
            chk({name, "_in_ready_after"},  int'(in_ready),  1);
            chk({name, "_out_valid_after"}, int'(out_valid), 0);
            chk({name, "_out_class_after"}, int'(out_class), 0);
            chk({name, "_out_count_after"}, int'(out_count), 0);
        end
    endtask

    initial begin
        vec_t v;
        int   hits;
        int   n;

        vecs[0] = mk(1, 1, 1, 2, 3, 1, 13, 1,   1, 5, 0);
        vecs[1] = mk(6, 6, 6, 6, 2, 2, 2, 2,    2, 4, 1);
        vecs[2] = mk(31, 31, 0, 0, 0, 31, 31, 31, 31, 5, 0);
        vecs[3] = mk(7, 6, 5, 4, 3, 2, 1, 0,    0, 1, 1);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0,    0, 8, 0);
        vecs[5] = mk(4, 4, 9, 9, 9, 4, 9, 4,    4, 4, 1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_class = '0; out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_class = '0; b_out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_tie",   int'(out_tie),   0);
        chk("rst_err_range", int'(err_range), 0);

        for (int k = 0; k < 6; k++) begin
            send_window(vecs[k], 1'b1);
            wait_result($sformatf("vec%0d", k));
        end

        // Backpressure: result must hold, and inputs must be refused.
        out_ready = 1'b0;
        send_window(mk(7, 7, 7, 7, 7, 7, 7, 7, 7, 8, 0), 1'b1);
        wait_result("bp");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_class = 5'd3;
            step();
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_class", int'(out_class), 7);
            chk("bp_hold_count", int'(out_count), 8);
            chk("bp_hold_ready", int'(in_ready),  0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", int'(in_ready),  1);
        chk("bp_release_valid", int'(out_valid), 0);
        send_window(mk(4, 4, 4, 4, 4, 4, 4, 4, 4, 8, 0), 1'b1);
        wait_result("bp_next");

        // Flush drops the partial window and the sample offered alongside it.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_class = 5'd9;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        send_window(mk(19, 19, 19, 19, 19, 19, 19, 19, 19, 8, 0), 1'b1);
        wait_result("flush");

        // Reset in the middle of SCAN discards the result.
        send_window(mk(5, 5, 5, 5, 5, 5, 5, 5, 5, 8, 0), 1'b0);
        repeat (5) step();
        chk("scan_in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("scan_rst_in_ready",  int'(in_ready),  1);
        chk("scan_rst_out_valid", int'(out_valid), 0);
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid) hits++;
        end
        chk("scan_rst_no_valid", hits, 0);
        send_window(mk(10, 10, 10, 11, 11, 12, 12, 12, 10, 3, 1), 1'b1);
        wait_result("after_rst");
        chk("err_range_main", int'(err_range), 0);

        // Out-of-range labels on the N_CLASSES=10 instance.
        chk("b_err_before", int'(b_err_range), 0);
        v = mk(12, 12, 12, 12, 12, 5, 5, 5, 5, 3, 0);
        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1;
            b_in_class = v.labs[i];
            step();
        end
        b_in_valid = 1'b0;
        chk("b_err_set", int'(b_err_range), 1);
        n = 0;
        while (!b_out_valid && n < 200) begin
            step();
            n++;
        end
        chk("b_latency",   n, 10);
        chk("b_out_class", int'(b_out_class), 5);
        chk("b_out_count", int'(b_out_count), 3);
        chk("b_out_tie",   int'(b_out_tie),   0);
        step();
        chk("b_in_ready_after", int'(b_in_ready),  1);
        chk("b_err_sticky",     int'(b_err_range), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
